// File: rtl/fixed_subframe_encoder.sv
// FLAC SUBFRAME_FIXED encoder: header, verbatim warmup, single-partition Rice residuals,
// packed MSB-first into 16-bit RAM words through a 32-bit bit accumulator.
module fixed_subframe_encoder #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iStart,
  input  logic [2:0]            iOrder,
  input  logic [3:0]            iRiceParam,
  input  logic [15:0]           iBlockSize,
  input  logic [ADDR_WIDTH-1:0] iBaseAddr,
  input  logic [15:0]           iSample,
  input  logic                  iSampleValid,
  output logic                  oSampleReady,
  output logic [15:0]           oWriteData,
  output logic [ADDR_WIDTH-1:0] oWriteAddr,
  output logic                  oWriteEnable,
  output logic                  oBusy,
  output logic                  oFrameDone,
  output logic                  oError
);

  typedef enum logic [3:0] {
    S_IDLE, S_HEADER, S_WARM, S_RES_HDR, S_RESIDUAL, S_UNARY, S_LOWBITS, S_FLUSH, S_DONE
  } state_t;

  state_t                state;
  logic [2:0]            order;
  logic [3:0]            rice_k;
  logic [15:0]           block_size;
  logic [15:0]           sample_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           acc;
  logic [5:0]            fill;
  logic [15:0]           h1, h2, h3, h4;
  logic [20:0]           u;
  logic [20:0]           q;

  logic        do_write, room, app_fire, params_bad, sample_take, last_sample;
  logic [31:0] acc_w, app_ext;
  logic [5:0]  fill_w;
  logic [4:0]  app_n;
  logic [15:0] app_v, app_left;
  logic [19:0] xs, h1s, h2s, h3s, h4s, r;
  logic [20:0] u_c;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    do_write = (fill >= 6'd16) || (state == S_FLUSH && fill != 6'd0);
    acc_w    = do_write ? {acc[15:0], 16'h0000} : acc;
    fill_w   = do_write ? ((fill >= 6'd16) ? fill - 6'd16 : 6'd0) : fill;

    app_n = 5'd0;
    app_v = 16'h0000;
    case (state)
      S_HEADER:  begin app_n = 5'd8;  app_v = {8'h00, 4'b0001, order, 1'b0}; end
      S_WARM:    begin app_n = 5'd16; app_v = iSample; end
      S_RES_HDR: begin app_n = 5'd10; app_v = {6'b0, 2'b00, 4'b0000, rice_k}; end
      S_UNARY: begin
        if (|q[20:4]) begin app_n = 5'd16; app_v = 16'h0000; end
        else          begin app_n = {1'b0, q[3:0]} + 5'd1; app_v = 16'h0001; end
      end
      S_LOWBITS: begin app_n = {1'b0, rice_k}; app_v = u[15:0]; end
      default:   ;
    endcase

    // Left-justify the append, then slide it just below the bits already held.
    app_left = app_v << (5'd16 - app_n);
    app_ext  = {app_left, 16'h0000} >> fill_w;
    room     = ({1'b0, fill_w} + {2'b00, app_n}) <= 7'd32;

    oSampleReady = room && (state == S_WARM || state == S_RESIDUAL);
    sample_take  = oSampleReady && iSampleValid;
    app_fire     = room && (state == S_HEADER || state == S_RES_HDR || state == S_UNARY ||
                            state == S_LOWBITS || (state == S_WARM && iSampleValid));
    last_sample  = (sample_cnt == block_size);

    xs  = {{4{iSample[15]}}, iSample};
    h1s = {{4{h1[15]}}, h1};
    h2s = {{4{h2[15]}}, h2};
    h3s = {{4{h3[15]}}, h3};
    h4s = {{4{h4[15]}}, h4};
    case (order)
      3'd0:    r = xs;
      3'd1:    r = xs - h1s;
      3'd2:    r = xs - (h1s << 1) + h2s;
      3'd3:    r = xs - ((h1s << 1) + h1s) + ((h2s << 1) + h2s) - h3s;
      default: r = xs - (h1s << 2) + ((h2s << 2) + (h2s << 1)) - (h3s << 2) + h4s;
    endcase
    // Zigzag fold: 2r for r>=0, -2r-1 (= ~2r) otherwise.
    u_c = {r, 1'b0} ^ {21{r[19]}};

    params_bad = (iOrder > 3'd4) || (iRiceParam == 4'd15) || (iBlockSize <= {13'd0, iOrder});
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state        <= S_IDLE;
      order        <= '0;
      rice_k       <= '0;
      block_size   <= '0;
      sample_cnt   <= '0;
      addr         <= '0;
      acc          <= '0;
      fill         <= '0;
      h1           <= '0;
      h2           <= '0;
      h3           <= '0;
      h4           <= '0;
      u            <= '0;
      q            <= '0;
      oWriteData   <= '0;
      oWriteAddr   <= '0;
      oWriteEnable <= 1'b0;
      oBusy        <= 1'b0;
      oFrameDone   <= 1'b0;
      oError       <= 1'b0;
    end else begin
      oWriteEnable <= do_write;
      oFrameDone   <= 1'b0;
      oError       <= 1'b0;
      if (do_write) begin
        oWriteData <= acc[31:16];
        oWriteAddr <= addr;
        addr       <= addr + 1'b1;
      end
      acc  <= app_fire ? (acc_w | app_ext) : acc_w;
      fill <= fill_w + (app_fire ? {1'b0, app_n} : 6'd0);

      if (sample_take) begin
        h1         <= iSample;
        h2         <= h1;
        h3         <= h2;
        h4         <= h3;
        sample_cnt <= sample_cnt + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (iStart) begin
            if (params_bad) begin
              oError <= 1'b1;
            end else begin
              order      <= iOrder;
              rice_k     <= iRiceParam;
              block_size <= iBlockSize;
              addr       <= iBaseAddr;
              sample_cnt <= '0;
              oBusy      <= 1'b1;
              state      <= S_HEADER;
            end
          end
        end
        S_HEADER:  if (app_fire) state <= (order != 3'd0) ? S_WARM : S_RES_HDR;
        S_WARM:    if (sample_take && (sample_cnt + 16'd1 == {13'd0, order})) state <= S_RES_HDR;
        S_RES_HDR: if (app_fire) state <= S_RESIDUAL;
        S_RESIDUAL: begin
          if (sample_take) begin
            u     <= u_c;
            q     <= u_c >> rice_k;
            state <= S_UNARY;
          end
        end
        S_UNARY: begin
          if (app_fire) begin
            if (|q[20:4])            q     <= q - 21'd16;
            else if (rice_k != 4'd0) state <= S_LOWBITS;
            else                     state <= last_sample ? S_FLUSH : S_RESIDUAL;
          end
        end
        S_LOWBITS: if (app_fire) state <= last_sample ? S_FLUSH : S_RESIDUAL;
        S_FLUSH:   if (fill <= 6'd16) state <= S_DONE;
        S_DONE: begin
          oFrameDone <= 1'b1;
          oBusy      <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_subframe_encoder.sv
// Scoreboard bench for fixed_subframe_encoder: directed frames push expected RAM writes,
// a negedge monitor pops and compares every write strobe.
module tb_fixed_subframe_encoder;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iStart = 1'b0;
  logic [2:0]  iOrder = '0;
  logic [3:0]  iRiceParam = '0;
  logic [15:0] iBlockSize = '0;
  logic [15:0] iBaseAddr = '0;
  logic [15:0] iSample = '0;
  logic        iSampleValid = 1'b0;
  logic        oSampleReady;
  logic [15:0] oWriteData;
  logic [15:0] oWriteAddr;
  logic        oWriteEnable;
  logic        oBusy;
  logic        oFrameDone;
  logic        oError;

  fixed_subframe_encoder #(.ADDR_WIDTH(16)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iOrder(iOrder),
    .iRiceParam(iRiceParam), .iBlockSize(iBlockSize), .iBaseAddr(iBaseAddr),
    .iSample(iSample), .iSampleValid(iSampleValid), .oSampleReady(oSampleReady),
    .oWriteData(oWriteData), .oWriteAddr(oWriteAddr), .oWriteEnable(oWriteEnable),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oError(oError)
  );

  always #5 iClock = ~iClock;

  typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  wr_count = 0;
  int  err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oError) err_seen++;
      if (oWriteEnable) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got 0x%0h@0x%0h expected no write", oWriteData, oWriteAddr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {16'h0, oWriteAddr}, {16'h0, e.addr});
          check("wr_data", {16'h0, oWriteData}, {16'h0, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [2:0] o, input logic [3:0] k, input logic [15:0] bs,
                       input logic [15:0] base);
    @(posedge iClock); #1;
    iOrder = o; iRiceParam = k; iBlockSize = bs; iBaseAddr = base;
    iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    err_seen = 0;
    check("busy_after_start", {31'd0, oBusy}, 32'd1);
  endtask

  task automatic feed(input logic [15:0] s, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    iSample = s;
    iSampleValid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge iClock);
      if (oSampleReady) begin got = 1'b1; break; end
      waited++;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL feed_timeout: got no oSampleReady expected ready within 200 cycles");
    end
    @(posedge iClock); #1;
    iSampleValid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_writes, input int wr_base);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge iClock);
      if (oFrameDone) begin got = 1'b1; break; end
    end
    check({name, "_done"}, {31'd0, got}, 32'd1);
    check({name, "_busy_clear"}, {31'd0, oBusy}, 32'd0);
    check({name, "_writes"}, wr_count - wr_base, exp_writes);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_no_error"}, err_seen, 0);
  endtask

  task automatic bad_start(input string name, input logic [2:0] o, input logic [3:0] k,
                           input logic [15:0] bs);
    int wb;
    wb = wr_count;
    @(posedge iClock); #1;
    iOrder = o; iRiceParam = k; iBlockSize = bs; iBaseAddr = 16'h0300;
    iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    check({name, "_error_pulse"}, {31'd0, oError}, 32'd1);
    check({name, "_busy"}, {31'd0, oBusy}, 32'd0);
    @(posedge iClock); #1;
    check({name, "_error_clear"}, {31'd0, oError}, 32'd0);
    repeat (3) @(posedge iClock);
    #1;
    check({name, "_no_writes"}, wr_count - wb, 0);
  endtask

  initial begin
    int w;
    int wb;
    bit got;

    #12;
    check("rst_we",    {31'd0, oWriteEnable}, 32'd0);
    check("rst_busy",  {31'd0, oBusy}, 32'd0);
    check("rst_ready", {31'd0, oSampleReady}, 32'd0);
    check("rst_wdata", {16'd0, oWriteData}, 32'd0);
    @(negedge iClock);
    iReset = 1'b0;

    // Order 0, k=0, samples 0,-1: 0x1000, 0x2800.
    wb = wr_count;
    expect_wr(16'h0000, 16'h1000);
    expect_wr(16'h0001, 16'h2800);
    start(3'd0, 4'd0, 16'd2, 16'h0000);
    feed(16'h0000, w);
    feed(16'hFFFF, w);
    wait_done("ord0", 2, wb);

    // Order 1, k=2, samples 100,103,101.
    wb = wr_count;
    expect_wr(16'h0010, 16'h1200);
    expect_wr(16'h0011, 16'h6400);
    expect_wr(16'h0012, 16'h9B80);
    start(3'd1, 4'd2, 16'd3, 16'h0010);
    feed(16'd100, w);
    feed(16'd103, w);
    feed(16'd101, w);
    check("ord1_ready_stall", {31'd0, w > 0}, 32'd1);
    wait_done("ord1", 3, wb);

    // Order 0, k=0, sample 20: 40 unary zeros then a one; 59 bits, last word flushed.
    wb = wr_count;
    expect_wr(16'h0100, 16'h1000);
    expect_wr(16'h0101, 16'h0000);
    expect_wr(16'h0102, 16'h0000);
    expect_wr(16'h0103, 16'h0020);
    start(3'd0, 4'd0, 16'd1, 16'h0100);
    feed(16'd20, w);
    wait_done("long_unary", 4, wb);

    // Order 2, k=1, samples 10,20,25: r=-5, u=9.
    wb = wr_count;
    expect_wr(16'h0200, 16'h1400);
    expect_wr(16'h0201, 16'h0A00);
    expect_wr(16'h0202, 16'h1400);
    expect_wr(16'h0203, 16'h4300);
    start(3'd2, 4'd1, 16'd3, 16'h0200);
    feed(16'd10, w);
    feed(16'd20, w);
    feed(16'd25, w);
    wait_done("ord2", 4, wb);

    // Order 4, k=2, samples 1,2,3,4,2: r=-3, u=5.
    wb = wr_count;
    expect_wr(16'h0210, 16'h1800);
    expect_wr(16'h0211, 16'h0100);
    expect_wr(16'h0212, 16'h0200);
    expect_wr(16'h0213, 16'h0300);
    expect_wr(16'h0214, 16'h0400);
    expect_wr(16'h0215, 16'h9400);
    start(3'd4, 4'd2, 16'd5, 16'h0210);
    feed(16'd1, w);
    feed(16'd2, w);
    feed(16'd3, w);
    feed(16'd4, w);
    feed(16'd2, w);
    wait_done("ord4", 6, wb);

    bad_start("bad_order", 3'd5, 4'd2, 16'd8);
    bad_start("bad_k",     3'd1, 4'd15, 16'd8);
    bad_start("bad_block", 3'd2, 4'd2, 16'd2);

    // Reset while the encoder waits in the residual state.
    expect_wr(16'h0020, 16'h1200);
    expect_wr(16'h0021, 16'h6400);
    start(3'd1, 4'd2, 16'd3, 16'h0020);
    feed(16'd100, w);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge iClock);
      if (oSampleReady) begin got = 1'b1; break; end
    end
    check("mid_reset_reached_residual", {31'd0, got}, 32'd1);
    @(negedge iClock);
    @(negedge iClock);
    #1;
    iReset = 1'b1;
    #1;
    check("mid_reset_busy",  {31'd0, oBusy}, 32'd0);
    check("mid_reset_ready", {31'd0, oSampleReady}, 32'd0);
    check("mid_reset_we",    {31'd0, oWriteEnable}, 32'd0);
    check("mid_reset_addr",  {16'd0, oWriteAddr}, 32'd0);
    check("mid_reset_pending", exp_q.size(), 0);
    repeat (2) @(negedge iClock);
    iReset = 1'b0;

    wb = wr_count;
    expect_wr(16'h0040, 16'h1000);
    expect_wr(16'h0041, 16'h2800);
    start(3'd0, 4'd0, 16'd2, 16'h0040);
    feed(16'h0000, w);
    feed(16'hFFFF, w);
    wait_done("after_reset", 2, wb);

    // Address wrap with a second iStart issued while busy.
    wb = wr_count;
    expect_wr(16'hFFFF, 16'h1200);
    expect_wr(16'h0000, 16'h6400);
    expect_wr(16'h0001, 16'h9B80);
    start(3'd1, 4'd2, 16'd3, 16'hFFFF);
    @(posedge iClock); #1;
    iOrder = 3'd0; iRiceParam = 4'd0; iBlockSize = 16'd1; iBaseAddr = 16'h5555;
    iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    check("restart_ignored_busy", {31'd0, oBusy}, 32'd1);
    feed(16'd100, w);
    feed(16'd103, w);
    feed(16'd101, w);
    wait_done("wrap", 3, wb);

    repeat (4) @(posedge iClock);
    #1;
    check("final_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
